// File: rtl/je_raster_writer_pkg.sv
// Shared types and constants for the raster writer and its block scanner.
package je_raster_writer_pkg;

    // Frame-level controller states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Legal block edges and bytes-per-pixel range.
    localparam int BLK_SMALL = 8;
    localparam int BLK_LARGE = 16;
    localparam int BPP_MIN   = 1;
    localparam int BPP_MAX   = 4;

    // Width of the byte-within-pixel index (covers BPP_MAX).
    localparam int BYTE_W = 2;

    // Number of low column/row bits that index a pixel inside one block.
    function automatic int blk_lsb(input int blk);
        return (blk == BLK_LARGE) ? 4 : 3;
    endfunction

endpackage

// File: rtl/je_raster_writer_if.sv
// Encoder-input and memory-write bus of the raster writer.
interface je_raster_writer_if #(
    parameter int ASZ = 17
);
    logic           in_valid;
    logic [7:0]     in_data;
    logic           in_ready;
    logic           mem_ready;
    logic [ASZ-1:0] addr;
    logic [7:0]     data;
    logic           we;

    // Environment side: encoder byte source plus memory.
    modport master (
        output in_valid, in_data, mem_ready,
        input  in_ready, addr, data, we
    );

    // Writer side.
    modport slave (
        input  in_valid, in_data, mem_ready,
        output in_ready, addr, data, we
    );
endinterface

// File: rtl/je_raster_writer_blk_scan.sv
// je_blk_scan: walks byte -> pixel -> block row -> block -> block band order
// and reports the current pixel column/row, byte index and last-byte flag.
module je_blk_scan
    import je_raster_writer_pkg::*;
#(
    parameter int WSZ = 9,
    parameter int HSZ = 8,
    parameter int BPP = 2,
    parameter int BLK = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              advance,
    input  logic [WSZ-1:0]    width,
    input  logic [HSZ-1:0]    height,
    output logic [WSZ-1:0]    col,
    output logic [HSZ-1:0]    row,
    output logic [BYTE_W-1:0] byte_idx,
    output logic              last
);

    localparam int LSB = blk_lsb(BLK);

    logic [WSZ-1:0]    col_q, col_d, bx_q, bx_d;
    logic [HSZ-1:0]    row_q, row_d, by_q, by_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [WSZ-1:0]    width_m1;
    logic [HSZ-1:0]    height_m1;
    logic              byte_end, col_end, row_end, blk_more;

    assign width_m1  = width - WSZ'(1);
    assign height_m1 = height - HSZ'(1);
    assign byte_end  = (byte_q == BYTE_W'(BPP - 1));
    // A block row ends at the frame edge or at the block's right edge.
    assign col_end   = (col_q == width_m1) || (&col_q[LSB-1:0]);
    assign row_end   = (row_q == height_m1) || (&row_q[LSB-1:0]);
    assign blk_more  = ({1'b0, bx_q} + (WSZ+1)'(BLK)) < {1'b0, width};

    // Next position in block order.
    always_comb begin
        // NOTE: every next-state variable gets a default first so no path leaves it unassigned and infers a latch.
        col_d  = col_q;
        row_d  = row_q;
        bx_d   = bx_q;
        by_d   = by_q;
        byte_d = byte_q;
        if (clear) begin
            col_d  = '0;
            row_d  = '0;
            bx_d   = '0;
            by_d   = '0;
            byte_d = '0;
        end else if (advance) begin
            if (!byte_end) begin
                byte_d = byte_q + BYTE_W'(1);
            end else begin
                byte_d = '0;
                if (!col_end) begin
                    col_d = col_q + WSZ'(1);
                end else if (!row_end) begin
                    col_d = bx_q;
                    row_d = row_q + HSZ'(1);
                end else if (blk_more) begin
                    bx_d  = bx_q + WSZ'(BLK);
                    col_d = bx_q + WSZ'(BLK);
                    row_d = by_q;
                end else begin
                    bx_d  = '0;
                    col_d = '0;
                    by_d  = by_q + HSZ'(BLK);
                    row_d = by_q + HSZ'(BLK);
                end
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q  <= '0;
            row_q  <= '0;
            bx_q   <= '0;
            by_q   <= '0;
            byte_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            bx_q   <= bx_d;
            by_q   <= by_d;
            byte_q <= byte_d;
        end
    end

    assign col      = col_q;
    assign row      = row_q;
    assign byte_idx = byte_q;
    assign last     = byte_end && (col_q == width_m1) && (row_q == height_m1);

endmodule

// File: rtl/je_raster_writer.sv
// Raster writer: takes block-ordered encoder bytes and writes them to a
// double-buffered raster frame in memory, one cycle after acceptance.
module je_raster_writer
    import je_raster_writer_pkg::*;
#(
    parameter int ASZ = 17,
    parameter int WSZ = 9,
    parameter int HSZ = 8,
    parameter int BPP = 2,
    parameter int BLK = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic           abort,
    input  logic [WSZ-1:0] cfg_width,
    input  logic [HSZ-1:0] cfg_height,
    input  logic [ASZ-1:0] cfg_base0,
    input  logic [ASZ-1:0] cfg_base1,
    je_raster_writer_if.slave bus,
    output logic           busy,
    output logic           frame_done,
    output logic           buf_sel,
    output logic           err_cfg
);

    state_e            state_q, state_d;
    logic [WSZ-1:0]    width_q;
    logic [HSZ-1:0]    height_q;
    logic [ASZ-1:0]    base_q;
    logic              buf_sel_q, err_cfg_q;
    logic [ASZ-1:0]    addr_q, addr_d;
    logic [7:0]        data_q;
    logic              we_q, frame_done_q;
    logic              in_ready, accept, cfg_ok, start_idle, start_ok, finish;
    logic [WSZ-1:0]    scan_col;
    logic [HSZ-1:0]    scan_row;
    logic [BYTE_W-1:0] scan_byte;
    logic              scan_last;

    assign cfg_ok     = (cfg_width != '0) && (cfg_height != '0);
    assign start_idle = start && !abort && (state_q == ST_IDLE);
    assign start_ok   = start_idle && cfg_ok;
    assign accept     = bus.in_valid && in_ready;
    // An abort on the final byte still writes it but is treated as an abort.
    assign finish     = accept && scan_last && !abort;

    je_blk_scan #(
        .WSZ (WSZ),
        .HSZ (HSZ),
        .BPP (BPP),
        .BLK (BLK)
    ) u_scan (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (start_ok),
        .advance  (accept),
        .width    (width_q),
        .height   (height_q),
        .col      (scan_col),
        .row      (scan_row),
        .byte_idx (scan_byte),
        .last     (scan_last)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: abort wins, otherwise start or final byte move the state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_RUN;
            ST_RUN:  if (abort || (accept && scan_last)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy     = (state_q == ST_RUN);
        in_ready = (state_q == ST_RUN) && bus.mem_ready;
    end

    // Frame configuration, buffer select and sticky config error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            width_q   <= '0;
            height_q  <= '0;
            base_q    <= '0;
            buf_sel_q <= 1'b0;
            err_cfg_q <= 1'b0;
        end else begin
            if (start_ok) begin
                width_q   <= cfg_width;
                height_q  <= cfg_height;
                base_q    <= buf_sel_q ? cfg_base1 : cfg_base0;
                err_cfg_q <= 1'b0;
            end else if (start_idle) begin
                err_cfg_q <= 1'b1;
            end
            if (finish) buf_sel_q <= ~buf_sel_q;
        end
    end

    // Raster address of the byte being accepted, wrapped to ASZ bits.
    always_comb begin
        addr_d = base_q
               + (ASZ'(scan_row) * ASZ'(width_q) + ASZ'(scan_col)) * ASZ'(BPP)
               + ASZ'(scan_byte);
    end

    // Write pipeline: one cycle from acceptance to the memory write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= '0;
            data_q       <= '0;
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            we_q         <= accept;
            frame_done_q <= finish;
            if (accept) begin
                addr_q <= addr_d;
                data_q <= bus.in_data;
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.addr     = addr_q;
    assign bus.data     = data_q;
    assign bus.we       = we_q;
    assign frame_done   = frame_done_q;
    assign buf_sel      = buf_sel_q;
    assign err_cfg      = err_cfg_q;

endmodule
